cpu_ctrl_mem: RTL

Multi-cycle CPU controller, the successor to the standalone FSM controller, with instruction fetch and memory access added.
- Owns the program counter (PC), the instruction register, the data-address register and a memory request/ready handshake.
- Drives the existing datapath control strobes, and adds LDR/STR, conditional branches and HALT.
- Sits between the memory and the datapath/decoder in the top-level CPU.

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/branch_cond_eval.sv | 26 ++
 rtl/cpu_ctrl_mem.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcode
// fields, memory command codes, one-hot select constants and branch conditions.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_C, S_MOVE,
    S_ADDR, S_LD_ADDR, S_MEM_RD, S_WR_M, S_GET_D, S_MEM_WR, S_BRANCH, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  // opcode = ir[15:13]
  localparam logic [2:0] OPC_BRANCH = 3'b001;
  localparam logic [2:0] OPC_LDR    = 3'b011;
  localparam logic [2:0] OPC_STR    = 3'b100;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_HALT   = 3'b111;

  // op = ir[12:11]
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;

  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_IMM   = 4'b0100;
  localparam logic [3:0] VSEL_MDATA = 4'b1000;

  // cond = ir[10:8]
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from the condition code and the latched status flags.
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  output logic       take
);

  // Signed less-than is N^V; unused condition codes never branch
  always_comb begin
    take = 1'b0;
    case (cond)
      COND_AL: take = 1'b1;
      COND_EQ: take = Z;
      COND_NE: take = ~Z;
      COND_LT: take = N ^ V;
      COND_LE: take = (N ^ V) | Z;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_mem.sv
// Multi-cycle CPU controller with instruction fetch, load/store, conditional
// branches and halt. Owns PC, IR and the data-address register; all datapath
// strobes are Moore outputs decoded from state and IR.
module cpu_ctrl_mem
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic              N,
  input  logic              V,
  input  logic              Z,
  input  logic [15:0]       dp_out,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [2:0]        nsel,
  output logic [3:0]        vsel,
  output logic              asel,
  output logic              bsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic [1:0]        ALUop,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] RESET_PC_T = ADDR_W'(RESET_PC);

  state_t            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic              take;
  logic [ADDR_W-1:0] br_off;
  mem_cmd_t          cmd;

  assign opcode    = ir_q[15:13];
  assign op        = ir_q[12:11];
  assign br_off    = ADDR_W'(signed'(ir_q[7:0]));
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign mem_wdata = dp_out;

  branch_cond_eval u_cond (
    .cond (ir_q[10:8]),
    .N    (N),
    .V    (V),
    .Z    (Z),
    .take (take)
  );

  // State, PC, IR and address registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC_T;
      ir_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OPC_MOV:    state_d = (op == OP_MOV_IMM) ? S_WR_IMM :
                                (op == OP_MOV_REG) ? S_GET_B  : S_FETCH;
          OPC_ALU:    state_d = (op == OP_MVN) ? S_GET_B : S_GET_A;
          OPC_LDR,
          OPC_STR:    state_d = S_GET_A;
          OPC_BRANCH: state_d = S_BRANCH;
          OPC_HALT:   state_d = S_HALT;
          default:    state_d = S_FETCH;
        endcase
      end
      S_WR_IMM:  state_d = S_FETCH;
      S_GET_A:   state_d = (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
      S_GET_B:   state_d = (opcode == OPC_MOV) ? S_MOVE : S_EXEC;
      S_EXEC:    state_d = (op == OP_CMP) ? S_FETCH : S_WR_C;
      S_WR_C:    state_d = S_FETCH;
      S_MOVE:    state_d = (opcode == OPC_STR) ? S_MEM_WR : S_WR_C;
      S_ADDR:    state_d = S_LD_ADDR;
      S_LD_ADDR: begin
        addr_d  = dp_out[ADDR_W-1:0];
        state_d = (opcode == OPC_LDR) ? S_MEM_RD : S_GET_D;
      end
      S_MEM_RD:  if (mem_ready) state_d = S_WR_M;
      S_WR_M:    state_d = S_FETCH;
      S_GET_D:   state_d = S_MOVE;
      S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
      S_BRANCH: begin
        if (take) pc_d = pc_q + br_off;
        state_d = S_FETCH;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode from state and IR
  always_comb begin
    nsel     = NSEL_RN;
    vsel     = VSEL_C;
    asel     = 1'b0;
    bsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    ALUop    = 2'b00;
    halted   = 1'b0;
    cmd      = MEM_NONE;
    mem_addr = pc_q;
    case (state_q)
      S_FETCH:   cmd = MEM_READ;
      S_WR_IMM:  begin vsel = VSEL_IMM;   nsel = NSEL_RN; write = 1'b1; end
      S_GET_A:   begin nsel = NSEL_RN;    loada = 1'b1; end
      S_GET_B:   begin nsel = NSEL_RM;    loadb = 1'b1; end
      S_EXEC:    begin ALUop = op; loadc = 1'b1; loads = (op == OP_CMP); end
      S_WR_C:    begin vsel = VSEL_C;     nsel = NSEL_RD; write = 1'b1; end
      S_MOVE:    begin asel = 1'b1;       loadc = 1'b1; end
      S_ADDR:    begin bsel = 1'b1;       loadc = 1'b1; end
      S_MEM_RD:  begin cmd = MEM_READ;    mem_addr = addr_q; end
      S_WR_M:    begin vsel = VSEL_MDATA; nsel = NSEL_RD; write = 1'b1; end
      S_GET_D:   begin nsel = NSEL_RD;    loadb = 1'b1; end
      S_MEM_WR:  begin cmd = MEM_WRITE;   mem_addr = addr_q; end
      S_HALT:    halted = 1'b1;
      default:   ;
    endcase
  end

  // Reset forces state to FETCH, whose decode would issue READ; the command is
  // masked so memory sees NONE for as long as reset is held.
  assign mem_cmd = reset ? cmd : MEM_NONE;

endmodule
